// File: rtl/snoop_responder.sv
// Peer-side snoop responder: looks up snooped shared-bus operations in a local tag/MESI
// directory, answers MISS/HIT/HITM, flushes Modified lines. Optional SNOOP_STATS_EN adds result counters.
module snoop_responder #(
    parameter int addressSize    = 32,
    parameter int byteSelectBits = 6,
    parameter int indexBits      = 14,
    parameter int tagBits        = 12,
    parameter int ways           = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [addressSize-1:0]   sharedAddr,
    input  logic [7:0]               sharedOp,
    input  logic                     opValid,
    output logic                     busy,
    output logic                     snoopValid,
    output logic [1:0]               snoopResult,
    output logic                     writebackReq,
    output logic [addressSize-1:0]   writebackAddr,
    input  logic                     writebackAck,
    input  logic                     fillValid,
    input  logic [$clog2(ways)-1:0]  fillWay,
    input  logic [addressSize-1:0]   fillAddr,
    input  logic [3:0]               fillMesi,
    output logic                     fillReady
`ifdef SNOOP_STATS_EN
    ,
    output logic [31:0]              missCount,
    output logic [31:0]              hitCount,
    output logic [31:0]              hitmCount
`endif
);

    localparam int WAY_W  = $clog2(ways);
    localparam int SETS   = 1 << indexBits;
    localparam int LINE_W = addressSize - byteSelectBits;
    localparam int ENT_W  = tagBits + 4;

    localparam logic [3:0] MESI_M = 4'h1;
    localparam logic [3:0] MESI_S = 4'h4;
    localparam logic [3:0] MESI_I = 4'h8;

    localparam logic [1:0] RES_MISS = 2'b00;
    localparam logic [1:0] RES_HIT  = 2'b01;
    localparam logic [1:0] RES_HITM = 2'b10;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, WRITEBACK} state_t;

    state_t                  state_reg, state_next;
    logic [LINE_W-1:0]       line_addr_reg;
    logic                    is_read_reg;
    logic                    hit_reg, hit_m_reg;
    logic [WAY_W-1:0]        hit_way_reg;
    logic [1:0]              snoop_result_reg;

    logic                    op_known, accept, fill_we, upd_we;
    logic [3:0]              upd_mesi;
    logic [indexBits-1:0]    op_idx, fill_idx, idx_reg;
    logic [tagBits-1:0]      fill_tag, tag_reg;
    logic [ways-1:0]         hit_vec;
    logic [ways-1:0][3:0]    mesi_rd;
    logic [WAY_W-1:0]        lookup_way;
    logic                    lookup_hit, lookup_m;

    logic unused_offsets;
    assign unused_offsets = ^{sharedAddr[byteSelectBits-1:0], fillAddr[byteSelectBits-1:0]};

    assign op_known = (sharedOp == 8'h52) || (sharedOp == 8'h57) ||
                      (sharedOp == 8'h4D) || (sharedOp == 8'h49);
    assign op_idx   = sharedAddr[byteSelectBits +: indexBits];
    assign fill_idx = fillAddr[byteSelectBits +: indexBits];
    assign fill_tag = fillAddr[byteSelectBits+indexBits +: tagBits];
    assign idx_reg  = line_addr_reg[indexBits-1:0];
    assign tag_reg  = line_addr_reg[indexBits +: tagBits];
    assign fill_we  = fillValid && fillReady;
    assign upd_mesi = is_read_reg ? MESI_S : MESI_I;

    assign snoopResult   = snoop_result_reg;
    assign writebackAddr = {line_addr_reg, {byteSelectBits{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        busy         = (state_reg != IDLE);
        fillReady    = (state_reg == IDLE);
        snoopValid   = 1'b0;
        writebackReq = 1'b0;
        accept       = 1'b0;
        upd_we       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (opValid && op_known) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP:  state_next = RESPOND;
            RESPOND: begin
                snoopValid = 1'b1;
                if (hit_reg && hit_m_reg) begin
                    state_next = WRITEBACK;
                end else begin
                    upd_we     = hit_reg;
                    state_next = IDLE;
                end
            end
            WRITEBACK: begin
                writebackReq = 1'b1;
                if (writebackAck) begin
                    upd_we     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-way directory: {tag, mesi} in a RAM with registered read, plus a resettable valid bit
    // per set so reset invalidates every line at once. A fill coinciding with an accepted op is
    // forwarded into the read register so the lookup sees it.
    genvar gi;
    generate
        for (gi = 0; gi < ways; gi++) begin : g_way
            logic [ENT_W-1:0] entry_mem [SETS];
            logic [SETS-1:0]  valid_reg;
            logic [ENT_W-1:0] entry_rd_reg;
            logic             valid_rd_reg;
            logic             fill_this, upd_this, bypass;
            logic [3:0]       mesi_eff;

            assign fill_this = fill_we && (fillWay == WAY_W'(gi));
            assign upd_this  = upd_we && (hit_way_reg == WAY_W'(gi));
            assign bypass    = fill_this && (fill_idx == op_idx);

            always_ff @(posedge clk) begin
                if (fill_this)
                    entry_mem[fill_idx] <= {fill_tag, fillMesi};
                else if (upd_this)
                    entry_mem[idx_reg] <= {tag_reg, upd_mesi};
                if (accept)
                    entry_rd_reg <= bypass ? {fill_tag, fillMesi} : entry_mem[op_idx];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg    <= '0;
                    valid_rd_reg <= 1'b0;
                end else begin
                    if (fill_this)
                        valid_reg[fill_idx] <= 1'b1;
                    if (accept)
                        valid_rd_reg <= bypass | valid_reg[op_idx];
                end
            end

            assign mesi_eff    = valid_rd_reg ? entry_rd_reg[3:0] : MESI_I;
            assign mesi_rd[gi] = mesi_eff;
            assign hit_vec[gi] = (mesi_eff != MESI_I) && (entry_rd_reg[ENT_W-1:4] == tag_reg);
        end
    endgenerate

    always_comb begin
        lookup_way = '0;
        for (int w = ways - 1; w >= 0; w--) begin
            if (hit_vec[w])
                lookup_way = WAY_W'(w);
        end
    end
    assign lookup_hit = |hit_vec;
    assign lookup_m   = (mesi_rd[lookup_way] == MESI_M);

    always_ff @(posedge clk) begin
        if (reset) begin
            line_addr_reg    <= '0;
            is_read_reg      <= 1'b0;
            hit_reg          <= 1'b0;
            hit_m_reg        <= 1'b0;
            hit_way_reg      <= '0;
            snoop_result_reg <= RES_MISS;
        end else begin
            if (accept) begin
                line_addr_reg <= sharedAddr[addressSize-1:byteSelectBits];
                is_read_reg   <= (sharedOp == 8'h52);
            end
            if (state_reg == LOOKUP) begin
                hit_reg          <= lookup_hit;
                hit_m_reg        <= lookup_m;
                hit_way_reg      <= lookup_way;
                snoop_result_reg <= !lookup_hit ? RES_MISS : (lookup_m ? RES_HITM : RES_HIT);
            end
        end
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            missCount <= '0;
            hitCount  <= '0;
            hitmCount <= '0;
        end else if (snoopValid) begin
            if (snoop_result_reg == RES_MISS && missCount != 32'hFFFF_FFFF)
                missCount <= missCount + 32'd1;
            if (snoop_result_reg == RES_HIT && hitCount != 32'hFFFF_FFFF)
                hitCount <= hitCount + 32'd1;
            if (snoop_result_reg == RES_HITM && hitmCount != 32'hFFFF_FFFF)
                hitmCount <= hitmCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized self-checking bench for snoop_responder against a sparse directory model.
module tb_snoop_responder;

    localparam logic [7:0] OP_R = 8'h52, OP_W = 8'h57, OP_M = 8'h4D, OP_I = 8'h49, OP_X = 8'h58;
    localparam logic [3:0] ST_M = 4'h1, ST_E = 4'h2, ST_S = 4'h4, ST_I = 4'h8;
    localparam int SETS = 1 << 14;

    logic        clk, reset;
    logic [31:0] sharedAddr;
    logic [7:0]  sharedOp;
    logic        opValid, busy, snoopValid;
    logic [1:0]  snoopResult;
    logic        writebackReq;
    logic [31:0] writebackAddr;
    logic        writebackAck, fillValid;
    logic [2:0]  fillWay;
    logic [31:0] fillAddr;
    logic [3:0]  fillMesi;
    logic        fillReady;
`ifdef SNOOP_STATS_EN
    logic [31:0] missCount, hitCount, hitmCount;
`endif

    snoop_responder dut (
        .clk(clk), .reset(reset),
        .sharedAddr(sharedAddr), .sharedOp(sharedOp), .opValid(opValid),
        .busy(busy), .snoopValid(snoopValid), .snoopResult(snoopResult),
        .writebackReq(writebackReq), .writebackAddr(writebackAddr), .writebackAck(writebackAck),
        .fillValid(fillValid), .fillWay(fillWay), .fillAddr(fillAddr), .fillMesi(fillMesi),
        .fillReady(fillReady)
`ifdef SNOOP_STATS_EN
        , .missCount(missCount), .hitCount(hitCount), .hitmCount(hitmCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference directory: key = way*SETS + set index; absent key means Invalid.
    typedef struct packed {logic [11:0] tag; logic [3:0] mesi;} ent_t;
    ent_t dir [int];
    int   m_cnt [3];

    function automatic void m_reset();
        dir.delete();
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    endfunction

    function automatic void m_fill(input int way, input logic [31:0] addr, input logic [3:0] mesi);
        dir[way * SETS + int'(addr[19:6])] = '{tag: addr[31:20], mesi: mesi};
    endfunction

    // Result of a snoop and the final state it leaves behind (writeback assumed to complete).
    function automatic logic [1:0] m_snoop(input logic [7:0] op, input logic [31:0] addr, output bit is_m);
        logic [1:0] res;
        int key;
        res  = 2'b00;
        is_m = 0;
        for (int w = 0; w < 8; w++) begin
            key = w * SETS + int'(addr[19:6]);
            if (dir.exists(key) && dir[key].mesi != ST_I && dir[key].tag == addr[31:20]) begin
                is_m = (dir[key].mesi == ST_M);
                res  = is_m ? 2'b10 : 2'b01;
                dir[key].mesi = (op == OP_R) ? ST_S : ST_I;
                break;
            end
        end
        m_cnt[res]++;
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input int way, input logic [31:0] addr, input logic [3:0] mesi);
        fillValid = 1; fillWay = way[2:0]; fillAddr = addr; fillMesi = mesi;
        tick();
        fillValid = 0;
    endtask

    // Observations of one operation; edges are counted from the edge that sampled opValid (=0).
    int          obs_valid_edge, obs_idle_edge, obs_nvalid, obs_wb_cyc;
    logic [1:0]  obs_res;
    logic [31:0] obs_wb_addr;
    bit          obs_wb_stable;

    // delay < 0: ack held high throughout; else ack low for 'delay' request cycles, then high.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input int delay,
                          input bit fill_en, input int fway, input logic [31:0] faddr,
                          input logic [3:0] fmesi);
        sharedOp = op; sharedAddr = addr; opValid = 1;
        fillValid = fill_en; fillWay = fway[2:0]; fillAddr = faddr; fillMesi = fmesi;
        writebackAck = (delay < 0);
        tick();
        opValid = 0; fillValid = 0; sharedOp = 8'h00;
        obs_valid_edge = -1; obs_idle_edge = -1; obs_nvalid = 0; obs_wb_cyc = 0;
        obs_res = 2'b11; obs_wb_addr = '0; obs_wb_stable = 1;
        for (int c = 0; c < 40; c++) begin
            if (snoopValid) begin
                obs_nvalid++;
                if (obs_valid_edge < 0) begin
                    obs_valid_edge = c + 1;
                    obs_res = snoopResult;
                end
            end
            if (writebackReq) begin
                if (obs_wb_cyc == 0) obs_wb_addr = writebackAddr;
                else if (writebackAddr !== obs_wb_addr) obs_wb_stable = 0;
                obs_wb_cyc++;
                writebackAck = (delay < 0) || (obs_wb_cyc - 1 >= delay);
            end else begin
                writebackAck = (delay < 0);
            end
            if (!busy) begin
                obs_idle_edge = c + 1;
                break;
            end
            tick();
        end
        writebackAck = 0;
        $display("txn op=%h addr=%h valids=%0d result=%b wb_cycles=%0d idle_edge=%0d",
                 op, addr, obs_nvalid, obs_res, obs_wb_cyc, obs_idle_edge);
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        m_reset();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (snoopValid !== 1'b0) begin n_errors++; $display("FAIL reset_snoopValid: got %b want 0", snoopValid); end
        n_checks++; if (writebackReq !== 1'b0) begin n_errors++; $display("FAIL reset_wbreq: got %b want 0", writebackReq); end
        n_checks++; if (snoopResult !== 2'b00) begin n_errors++; $display("FAIL reset_result: got %b want 00", snoopResult); end
        n_checks++; if (writebackAddr !== 32'h0) begin n_errors++; $display("FAIL reset_wbaddr: got %h want 0", writebackAddr); end
        n_checks++; if (fillReady !== 1'b1) begin n_errors++; $display("FAIL reset_fillReady: got %b want 1", fillReady); end
        reset = 0;
        tick();
    endtask

    task automatic test_miss_latency();
        bit m;
        logic [1:0] exp;
        exp = m_snoop(OP_R, 32'h0000_1040, m);
        run_op(OP_R, 32'h0000_1040, 0, 0, 0, 0, 0);
        n_checks++; if (obs_valid_edge != 2) begin n_errors++; $display("FAIL miss_valid_edge: got %0d want 2", obs_valid_edge); end
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL miss_result: got %b want %b", obs_res, exp); end
        n_checks++; if (obs_idle_edge != 3) begin n_errors++; $display("FAIL miss_idle_edge: got %0d want 3", obs_idle_edge); end
        n_checks++; if (obs_wb_cyc != 0) begin n_errors++; $display("FAIL miss_no_wb: got %0d want 0", obs_wb_cyc); end
        n_checks++; if (obs_nvalid != 1) begin n_errors++; $display("FAIL miss_one_strobe: got %0d want 1", obs_nvalid); end
    endtask

    task automatic test_hit_transitions();
        logic [7:0] ops [4];
        bit m;
        logic [1:0] exp;
        ops = '{OP_R, OP_R, OP_I, OP_R};
        do_fill(3, 32'h0001_2040, ST_E);
        m_fill(3, 32'h0001_2040, ST_E);
        for (int k = 0; k < 4; k++) begin
            exp = m_snoop(ops[k], 32'h0001_2040, m);
            run_op(ops[k], 32'h0001_2040, 0, 0, 0, 0, 0);
            n_checks++; if (obs_res !== exp || obs_valid_edge != 2) begin
                n_errors++; $display("FAIL hit_seq[%0d]: got %b@%0d want %b@2", k, obs_res, obs_valid_edge, exp);
            end
        end
    endtask

    task automatic test_hitm_writeback();
        bit m;
        logic [1:0] exp;
        do_fill(0, 32'h0001_2057, ST_M);
        m_fill(0, 32'h0001_2057, ST_M);
        exp = m_snoop(OP_R, 32'h0001_2057, m);
        run_op(OP_R, 32'h0001_2057, 2, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL hitm_result: got %b want %b", obs_res, exp); end
        n_checks++; if (obs_wb_cyc != 3) begin n_errors++; $display("FAIL hitm_req_cycles: got %0d want 3", obs_wb_cyc); end
        n_checks++; if (obs_wb_addr !== 32'h0001_2040) begin n_errors++; $display("FAIL hitm_wbaddr: got %h want 00012040", obs_wb_addr); end
        n_checks++; if (!obs_wb_stable) begin n_errors++; $display("FAIL hitm_wbaddr_stable: got unstable want stable"); end
        n_checks++; if (obs_idle_edge != 6) begin n_errors++; $display("FAIL hitm_idle_edge: got %0d want 6", obs_idle_edge); end
        exp = m_snoop(OP_R, 32'h0001_2057, m);
        run_op(OP_R, 32'h0001_2057, 0, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL hitm_then_read: got %b want %b", obs_res, exp); end
    endtask

    task automatic test_ack_tied();
        bit m;
        logic [1:0] exp;
        do_fill(1, 32'h00A0_3380, ST_M);
        m_fill(1, 32'h00A0_3380, ST_M);
        exp = m_snoop(OP_W, 32'h00A0_33A4, m);
        run_op(OP_W, 32'h00A0_33A4, -1, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL acktied_result: got %b want %b", obs_res, exp); end
        n_checks++; if (obs_wb_cyc != 1) begin n_errors++; $display("FAIL acktied_req_cycles: got %0d want 1", obs_wb_cyc); end
        n_checks++; if (obs_wb_addr !== 32'h00A0_3380) begin n_errors++; $display("FAIL acktied_wbaddr: got %h want 00a03380", obs_wb_addr); end
        exp = m_snoop(OP_R, 32'h00A0_3380, m);
        run_op(OP_R, 32'h00A0_3380, 0, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL acktied_then_read: got %b want %b", obs_res, exp); end
    endtask

    task automatic test_fill_same_cycle();
        bit m;
        logic [1:0] exp;
        m_fill(6, 32'h00AB_C140, ST_S);
        exp = m_snoop(OP_M, 32'h00AB_C140, m);
        run_op(OP_M, 32'h00AB_C140, 0, 1, 6, 32'h00AB_C140, ST_S);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL samecycle_fill: got %b want %b", obs_res, exp); end
    endtask

    task automatic test_busy_ignore();
        bit m;
        logic [1:0] exp;
        int nv, nb;
        logic [1:0] r;
        do_fill(2, 32'h0003_4080, ST_E);
        m_fill(2, 32'h0003_4080, ST_E);
        exp = m_snoop(OP_R, 32'h0003_4080, m);
        sharedOp = OP_R; sharedAddr = 32'h0003_4080; opValid = 1;
        tick();
        // W to the same line and a fill, both while busy: must be dropped.
        sharedOp = OP_W; fillValid = 1; fillWay = 3'd5; fillAddr = 32'h0005_6100; fillMesi = ST_E;
        tick();
        opValid = 0; fillValid = 0; sharedOp = 8'h00;
        nv = 0; r = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (snoopValid) begin nv++; r = snoopResult; end
            tick();
        end
        n_checks++; if (nv != 1 || r !== exp) begin n_errors++; $display("FAIL busy_ignore_strobe: got %0d x %b want 1 x %b", nv, r, exp); end
        exp = m_snoop(OP_R, 32'h0003_4080, m);
        run_op(OP_R, 32'h0003_4080, 0, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL busy_op_dropped: got %b want %b", obs_res, exp); end
        exp = m_snoop(OP_R, 32'h0005_6100, m);
        run_op(OP_R, 32'h0005_6100, 0, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp) begin n_errors++; $display("FAIL busy_fill_dropped: got %b want %b", obs_res, exp); end
        run_op(OP_X, 32'h0003_4080, 0, 0, 0, 0, 0);
        nb = 0;
        for (int c = 0; c < 3; c++) begin
            if (busy || snoopValid) nb++;
            tick();
        end
        n_checks++; if (obs_nvalid != 0 || obs_idle_edge != 1 || nb != 0) begin
            n_errors++; $display("FAIL unknown_op: got strobes=%0d idle_edge=%0d busy=%0d want 0/1/0", obs_nvalid, obs_idle_edge, nb);
        end
    endtask

    task automatic test_random();
        logic [7:0] op_tbl [5];
        logic [7:0] op;
        logic [3:0] st_tbl [4];
        logic [31:0] addr, faddr;
        logic [1:0] exp;
        bit m, known, fen;
        int delay, fway, exp_wb;
        logic [3:0] fmesi;
        op_tbl = '{OP_R, OP_W, OP_M, OP_I, OP_X};
        st_tbl = '{ST_M, ST_E, ST_S, ST_I};
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                fway  = $urandom_range(0, 7);
                faddr = {12'($urandom_range(1, 2)), 14'($urandom_range(5, 6)), 6'($urandom_range(0, 63))};
                fmesi = st_tbl[$urandom_range(0, 3)];
                do_fill(fway, faddr, fmesi);
                m_fill(fway, faddr, fmesi);
            end
            fen   = ($urandom_range(0, 3) == 0);
            fway  = $urandom_range(0, 7);
            faddr = {12'($urandom_range(1, 2)), 14'($urandom_range(5, 6)), 6'($urandom_range(0, 63))};
            fmesi = st_tbl[$urandom_range(0, 2)];
            op    = op_tbl[($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3)];
            addr  = {12'($urandom_range(1, 2)), 14'($urandom_range(5, 6)), 6'($urandom_range(0, 63))};
            delay = $urandom_range(0, 3);
            known = (op != OP_X);
            if (fen) m_fill(fway, faddr, fmesi);
            exp = 2'b11; m = 0;
            if (known) exp = m_snoop(op, addr, m);
            exp_wb = m ? delay + 1 : 0;
            run_op(op, addr, delay, fen, fway, faddr, fmesi);
            n_checks++;
            if (!known) begin
                if (obs_nvalid != 0 || obs_idle_edge != 1) begin
                    n_errors++; $display("FAIL rand[%0d]_unknown: got strobes=%0d idle_edge=%0d want 0/1", i, obs_nvalid, obs_idle_edge);
                end
            end else if (obs_res !== exp || obs_nvalid != 1 || obs_valid_edge != 2 ||
                         obs_wb_cyc != exp_wb || obs_idle_edge != 3 + exp_wb ||
                         (exp_wb > 0 && (obs_wb_addr !== {addr[31:6], 6'b0} || !obs_wb_stable))) begin
                n_errors++;
                $display("FAIL rand[%0d]: got res=%b wb=%0d idle=%0d wbaddr=%h want res=%b wb=%0d idle=%0d wbaddr=%h",
                         i, obs_res, obs_wb_cyc, obs_idle_edge, obs_wb_addr, exp, exp_wb, 3 + exp_wb, {addr[31:6], 6'b0});
            end
        end
`ifdef SNOOP_STATS_EN
        n_checks++; if (missCount !== 32'(m_cnt[0]) || hitCount !== 32'(m_cnt[1]) || hitmCount !== 32'(m_cnt[2])) begin
            n_errors++; $display("FAIL stats_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                                 missCount, hitCount, hitmCount, m_cnt[0], m_cnt[1], m_cnt[2]);
        end
`endif
    endtask

    task automatic test_reset_mid_wb();
        bit m, seen;
        logic [1:0] exp;
        do_fill(4, 32'h0007_80C0, ST_M);
        m_fill(4, 32'h0007_80C0, ST_M);
        sharedOp = OP_R; sharedAddr = 32'h0007_80C0; opValid = 1; writebackAck = 0;
        tick();
        opValid = 0; sharedOp = 8'h00;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (writebackReq) begin seen = 1; break; end
            tick();
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL rstwb_reach_wb: got no writebackReq want writebackReq"); end
        reset = 1;
        tick();
        n_checks++; if (writebackReq !== 1'b0 || busy !== 1'b0 || snoopValid !== 1'b0) begin
            n_errors++; $display("FAIL rstwb_abort: got req=%b busy=%b valid=%b want 0/0/0", writebackReq, busy, snoopValid);
        end
        reset = 0;
        m_reset();
`ifdef SNOOP_STATS_EN
        n_checks++; if (missCount !== 32'h0 || hitCount !== 32'h0 || hitmCount !== 32'h0) begin
            n_errors++; $display("FAIL rstwb_stats_clear: got %0d/%0d/%0d want 0/0/0", missCount, hitCount, hitmCount);
        end
`endif
        tick();
        exp = m_snoop(OP_R, 32'h0007_80C0, m);
        run_op(OP_R, 32'h0007_80C0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_res !== exp || obs_nvalid != 1) begin
            n_errors++; $display("FAIL rstwb_then_read: got %b x%0d want %b x1", obs_res, obs_nvalid, exp);
        end
    endtask

    initial begin
        clk = 0; reset = 1;
        sharedAddr = '0; sharedOp = '0; opValid = 0; writebackAck = 0;
        fillValid = 0; fillWay = '0; fillAddr = '0; fillMesi = ST_I;
        test_reset();
        test_miss_latency();
        test_hit_transitions();
        test_hitm_writeback();
        test_ack_tied();
        test_fill_same_cycle();
        test_busy_ignore();
        test_random();
        test_reset_mid_wb();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
Peer-side responder on the shared bus. It watches operations issued by another L2 (R/W/M/I on the 8-bit shared operation bus) and looks the address up in a local tag/MESI directory. It answers on the 2-bit snoop bus with MISS/HIT/HITM, writes back Modified lines, and applies the resulting MESI transition. It is the answering end of the snoop exchange that each L2Cache initiates.

Parameters:
addressSize, 32, address width on the shared bus
byteSelectBits, 6, line offset bits (64-byte line)
indexBits, 14, set index bits
tagBits, 12, tag bits (addressSize - indexBits - byteSelectBits)
ways, 8, directory associativity

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
sharedAddr  in  addressSize  address of snooped operation
sharedOp  in  8  ASCII opcode: "R"=8'h52, "W"=8'h57, "M"=8'h4D, "I"=8'h49
opValid  in  1  one-cycle strobe qualifying sharedAddr/sharedOp
busy  out  1  responder occupied; opValid ignored while high
snoopValid  out  1  one-cycle strobe qualifying snoopResult
snoopResult  out  2  2'b00 MISS, 2'b01 HIT, 2'b10 HITM, 2'b11 never driven
writebackReq  out  1  level request to flush a Modified line
writebackAddr  out  addressSize  line-aligned address (offset bits zero)
writebackAck  in  1  writeback accepted
fillValid  in  1  local directory install
fillAddr  in  addressSize  address being installed
fillWay  in  $clog2(ways)  target way
fillMesi  in  4  one-hot MESI: M=1, E=2, S=4, I=8
fillReady  out  1  high only in IDLE

Behaviour:
- Reset: every directory entry mesi=I, tag=0; state IDLE; busy, snoopValid, writebackReq = 0; snoopResult = 2'b00; writebackAddr = 0.
- Reset mid-operation: the operation is aborted with no response strobe, and writebackReq is low the cycle after reset.
- FSM states: IDLE, LOOKUP, RESPOND, WRITEBACK.
- IDLE:
  - opValid with a recognised opcode: capture address and op, go to LOOKUP.
  - Unrecognised opcode: ignored, no response.
- Fill:
  - A fill with fillReady=1 writes tag and MESI to [fillWay][index] that edge.
  - Fill and opValid in the same IDLE cycle: both accepted. The lookup sees the filled entry.
  - fillValid while busy: dropped.
- LOOKUP (1 cycle):
  - Compare the tag against all ways whose mesi != I.
  - Multiple matches: the lowest way wins.
- RESPOND (1 cycle):
  - snoopValid=1.
  - Result is MISS if no match, HITM if the matched line is M, HIT if it is E or S.
  - Non-M match: apply the transition, go to IDLE.
  - M match: go to WRITEBACK.
  - MISS: no state change.
- Transitions:
  - "R": M->S (after writeback), E->S, S->S.
  - "W", "M", "I": any valid state -> I (M after writeback).
- WRITEBACK:
  - writebackReq=1, writebackAddr = captured address with byteSelect bits cleared, held stable.
  - On writebackAck, the transition is applied and writebackReq drops that edge; go to IDLE.
  - Ack in the first WRITEBACK cycle is legal.
- Latency: opValid at edge t -> snoopValid at t+2. busy is high from t+1 until IDLE is re-entered. Back-to-back throughput is one op per 3 cycles without writeback.
- busy = (state != IDLE). fillReady = (state == IDLE).

Optional Feature:
- Macro SNOOP_STATS_EN.
- When defined: adds outputs missCount, hitCount, hitmCount (32 bits each).
  - Each increments on its snoopValid strobe and saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then "R" @0x0000_1040 at edge t -> snoopValid=1 with result 2'b00 at t+2; busy low at t+3; no writebackReq.
- Fill way 3 addr 0x0001_2040 E; "R" same addr -> HIT (2'b01). A second "R" -> HIT, confirming state S. "I" -> HIT; a following "R" -> MISS.
- Fill way 0 addr 0x0001_2057 M; "R" -> HITM (2'b10) and writebackReq=1 with writebackAddr=0x0001_2040; ack 3 cycles late -> req held 3 cycles then drops; a following "R" -> HIT.
- Fill M then "W" with writebackAck tied high -> HITM, req high exactly one cycle; a following "R" -> MISS.
- opValid pulsed while busy -> ignored; opcode 8'h58 ("X") in IDLE -> no snoopValid, busy stays 0; fillValid while busy -> not installed (later "R" -> MISS).
- Reset asserted during WRITEBACK -> writebackReq=0 next cycle; a following "R" to the same addr -> MISS. With SNOOP_STATS_EN, all three counters read 0 after reset.
